// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer for the PWM core: steps duty toward a commanded target,
// updating only on PWM period boundaries (period_tick).
module pwm_fade_ctrl #(
  parameter int unsigned DUTY_W  = 8,
  parameter int unsigned STEP_W  = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               period_tick,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DUTY_W-1:0]  cmd_target,
  input  logic [STEP_W-1:0]  cmd_step,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  output logic [DUTY_W-1:0]  duty,
  output logic               busy,
  output logic               done
);

  localparam int unsigned ExtW = DUTY_W + 1;

  typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

  state_e               state_q, state_d;
  logic [DUTY_W-1:0]    duty_q, duty_d;
  logic [DUTY_W-1:0]    target_q, target_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [ExtW-1:0]      sum_ext, diff_ext;
  logic [DUTY_W-1:0]    up_val, down_val, next_val;

  // Saturating step toward target; one extra bit catches wrap/underflow.
  always_comb begin
    sum_ext  = {1'b0, duty_q} + ExtW'(step_q);
    diff_ext = {1'b0, duty_q} - ExtW'(step_q);
    if (step_q == '0 || sum_ext >= {1'b0, target_q}) begin
      up_val = target_q;
    end else begin
      up_val = sum_ext[DUTY_W-1:0];
    end
    if (step_q == '0 || diff_ext[DUTY_W] || diff_ext <= {1'b0, target_q}) begin
      down_val = target_q;
    end else begin
      down_val = diff_ext[DUTY_W-1:0];
    end
    next_val = (state_q == StRampUp) ? up_val : down_val;
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          step_d   = cmd_step;
          dwell_d  = cmd_dwell;
          cnt_d    = '0;
          if (cmd_target > duty_q) begin
            state_d = StRampUp;
            busy_d  = 1'b1;
          end else if (cmd_target < duty_q) begin
            state_d = StRampDown;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRampUp, StRampDown: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (period_tick) begin
          if (cnt_q == dwell_q) begin
            cnt_d  = '0;
            duty_d = next_val;
            if (next_val == target_q) begin
              state_d = StIdle;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign duty      = duty_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed scenarios plus random traffic,
// all compared every cycle against a behavioural fade model.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       period_tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_target = '0;
  logic [3:0] cmd_step = '0;
  logic [7:0] cmd_dwell = '0;
  logic       abort = 1'b0;
  logic [7:0] duty;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_duty = 0, m_target = 0, m_step = 0, m_dwell = 0, m_ticks = 0;
  bit m_active = 0, m_done = 0;

  pwm_fade_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .period_tick(period_tick),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .cmd_dwell  (cmd_dwell),
    .abort      (abort),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Fade advances once per (dwell+1) ticks counted after acceptance.
  task automatic model_edge(input bit tk, input bit v, input int tg, input int st,
                            input int dw, input bit ab);
    m_done = 0;
    if (!m_active) begin
      if (v) begin
        m_target = tg; m_step = st; m_dwell = dw; m_ticks = 0;
        if (tg != m_duty) m_active = 1;
        else m_done = 1;
      end
    end else if (ab) begin
      m_active = 0;
    end else if (tk) begin
      m_ticks++;
      if (m_ticks == m_dwell + 1) begin
        m_ticks = 0;
        if (m_step == 0) m_duty = m_target;
        else if (m_target > m_duty) m_duty = (m_duty + m_step > m_target) ? m_target
                                                                          : m_duty + m_step;
        else m_duty = (m_duty - m_step < m_target) ? m_target : m_duty - m_step;
        if (m_duty == m_target) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("duty", int'(duty), m_duty);
    check_eq("busy", int'(busy), int'(m_active));
    check_eq("done", int'(done), int'(m_done));
    check_eq("cmd_ready", int'(cmd_ready), int'(!m_active));
    check_eq("busy_and_done", int'(busy & done), 0);
  endtask

  task automatic cycle(input bit tk, input bit v, input int tg, input int st, input int dw,
                       input bit ab);
    @(negedge clk);
    period_tick = tk; cmd_valid = v; cmd_target = 8'(tg); cmd_step = 4'(st);
    cmd_dwell = 8'(dw); abort = ab;
    @(posedge clk);
    model_edge(tk, v, tg, st, dw, ab);
    #1;
    compare_all();
  endtask

  task automatic send(input int tg, input int st, input int dw);
    cycle(0, 1, tg, st, dw, 0);
  endtask

  // Tick followed by a quiet cycle.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    #12;
    rst_n = 1'b1;
    #1;
    compare_all();

    // Ramp up 0 -> 10 by 3
    send(10, 3, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      check_eq("rampup_duty", int'(duty), (i == 3) ? 10 : 3 * (i + 1));
      cycle(0, 0, 0, 0, 0, 0);
    end

    // Ramp down 10 -> 0 by 4 with dwell 2
    send(0, 4, 2);
    ticks(9);
    check_eq("rampdown_final", int'(duty), 0);

    // Abort coincident with a tick; cmd_valid held during ramp
    send(200, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 50, 2, 0, 0);
      cycle(0, 1, 50, 2, 0, 0);
    end
    cycle(1, 0, 0, 0, 0, 1);
    check_eq("abort_duty", int'(duty), 5);
    check_eq("abort_ready", int'(cmd_ready), 1);
    cycle(0, 0, 0, 0, 0, 0);

    // Boundaries
    send(250, 0, 0); ticks(1);
    send(255, 15, 0); ticks(1);
    check_eq("top_no_wrap", int'(duty), 255);
    send(3, 0, 0); ticks(1);
    send(0, 15, 0); ticks(1);
    check_eq("bottom_no_wrap", int'(duty), 0);
    send(128, 0, 0); ticks(1);
    check_eq("jump", int'(duty), 128);

    // No-op command
    send(42, 0, 0); ticks(1);
    send(42, 5, 1);
    check_eq("noop_done", int'(done), 1);
    cycle(0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-ramp
    send(0, 0, 0); ticks(1);
    send(100, 7, 0); ticks(1);
    check_eq("pre_reset_duty", int'(duty), 7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_duty = 0; m_active = 0; m_done = 0; m_ticks = 0;
    m_target = 0; m_step = 0; m_dwell = 0;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 99) < 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
